// File: rtl/aes_dec_stream_adapter_pkg.sv
// Shared types and constants for the AES decryption stream adapter.
// Block/word geometry and the adapter FSM state encoding.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_WORDS  = 4;
    localparam int AES_CNT_W  = 2;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_DONE,
        CAPTURE,
        DRAIN
    } aes_state_e;

endpackage

// File: rtl/aes_dec_stream_adapter_if.sv
// Stream and core-side signal bundle of the AES decryption adapter.
// slave = adapter view, master = environment (source, sink, core).
interface aes_dec_stream_adapter_if;
    import aes_pkg::*;

    logic                  in_valid;
    logic [AES_WORD_W-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [AES_WORD_W-1:0] out_data;
    logic                  out_ready;
    logic                  dec_enable;
    logic [AES_BLK_W-1:0]  dec_data;
    logic                  dec_done;
    logic [AES_BLK_W-1:0]  dec_result;
    logic                  busy;
    logic                  err_timeout;

    modport slave (
        input  in_valid, in_data, out_ready, dec_done, dec_result,
        output in_ready, out_valid, out_data, dec_enable, dec_data,
        output busy, err_timeout
    );

    modport master (
        output in_valid, in_data, out_ready, dec_done, dec_result,
        input  in_ready, out_valid, out_data, dec_enable, dec_data,
        input  busy, err_timeout
    );

endinterface

// File: rtl/aes_dec_stream_adapter_word_shifter.sv
// 128-bit register with parallel load and 32-bit shift-left.
// A 2-bit word counter tracks shifts; last_o marks the 4th word.
module aes_word_shifter
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load_i,
    input  logic [AES_BLK_W-1:0]  load_data_i,
    input  logic                  shift_i,
    input  logic [AES_WORD_W-1:0] shift_data_i,
    output logic [AES_BLK_W-1:0]  data_o,
    output logic                  last_o
);

    logic [AES_BLK_W-1:0] data_q, data_d;
    logic [AES_CNT_W-1:0] cnt_q, cnt_d;

    // Load restarts the word count; a shift moves one word up.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            data_d = {data_q[AES_BLK_W-AES_WORD_W-1:0], shift_data_i};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Buffer and counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign last_o = (cnt_q == AES_CNT_W'(AES_WORDS - 1));

endmodule

// File: rtl/aes_dec_stream_adapter.sv
// Stream front/back end of the AES-128 decryption core.
// Gathers 4 ciphertext words, pulses the core, drains 4 plaintext words.
module aes_dec_stream_adapter
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = 7
) (
    input logic                     clk,
    input logic                     n_rst,
    aes_dec_stream_adapter_if.slave bus
);

    aes_state_e state_q, state_d;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    logic in_ready, out_valid, dec_enable, busy;
    logic in_acc, out_acc;
    logic in_last, out_last;
    logic tmo_hit, tmo_fire;
    logic out_load;

    logic [AES_BLK_W-1:0] in_buf, out_buf, out_load_data;
    logic                 unused_out_low;

    assign in_acc   = bus.in_valid & in_ready;
    assign out_acc  = out_valid & bus.out_ready;
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tmo_fire = (state_q == WAIT_DONE) & ~bus.dec_done & tmo_hit;

    // A timeout loads zeros so the sink still sees a full block.
    assign out_load      = (state_q == CAPTURE) | tmo_fire;
    assign out_load_data = (state_q == CAPTURE) ? bus.dec_result : '0;

    aes_word_shifter u_in_shift (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_i       (1'b0),
        .load_data_i  ('0),
        .shift_i      (in_acc),
        .shift_data_i (bus.in_data),
        .data_o       (in_buf),
        .last_o       (in_last)
    );

    aes_word_shifter u_out_shift (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_i       (out_load),
        .load_data_i  (out_load_data),
        .shift_i      (out_acc),
        .shift_data_i ('0),
        .data_o       (out_buf),
        .last_o       (out_last)
    );

    assign unused_out_low = ^out_buf[AES_BLK_W-AES_WORD_W-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; done beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (in_acc && in_last) state_d = START;
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.dec_done)  state_d = CAPTURE;
                else if (tmo_hit)  state_d = DRAIN;
            end
            CAPTURE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_acc && out_last) state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // FSM outputs, decoded purely from the state.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dec_enable = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            START:     dec_enable = 1'b1;
            WAIT_DONE: ;
            CAPTURE:   ;
            DRAIN:     out_valid = 1'b1;
            default: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
        endcase
    end

    // Timeout counter and sticky error, cleared by the next block.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == START) begin
            tmo_d = '0;
        end else if (state_q == WAIT_DONE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (tmo_fire) begin
            err_d = 1'b1;
        end else if (in_acc) begin
            err_d = 1'b0;
        end
    end

    // Timeout and error registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_buf[AES_BLK_W-1 -: AES_WORD_W];
    assign bus.dec_enable  = dec_enable;
    assign bus.dec_data    = in_buf;
    assign bus.busy        = busy;
    assign bus.err_timeout = err_q;

endmodule
